// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - threshold-programmable synchronous FIFO with status flags
module fifo_umbral #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int UMBRAL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  input  logic [UMBRAL_WIDTH-1:0] Umbral_HIGH,
  input  logic [UMBRAL_WIDTH-1:0] Umbral_LOW,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    fifo_error,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic                    pop_ok;
  logic                    push_ok;
  logic                    err_cond;
  logic [UMBRAL_WIDTH-1:0] count_ext;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (ADDR_WIDTH+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
  assign pop_ok   = pop && !fifo_empty;
  assign push_ok  = push && (!fifo_full || pop_ok);
  assign err_cond = (push && fifo_full && !pop_ok) || (pop && fifo_empty);

  // Thresholds are compared against the zero-extended occupancy; zero disables a threshold.
  assign count_ext    = UMBRAL_WIDTH'(count);
  assign almost_full  = (Umbral_HIGH == '0) ? fifo_full  : (count_ext >= Umbral_HIGH);
  assign almost_empty = (Umbral_LOW  == '0) ? fifo_empty : (count_ext <= Umbral_LOW);

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, registered read port and sticky error flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (ADDR_WIDTH+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (ADDR_WIDTH+1)'(1);
      end
      if (err_cond) begin
        fifo_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - self-checking bench for fifo_umbral
`timescale 1ns/1ps
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [3:0] Umbral_HIGH;
  logic [3:0] Umbral_LOW;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;
  logic [5:0] sb[$];
  logic [5:0] exp_d;

  fifo_umbral dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .Umbral_HIGH(Umbral_HIGH), .Umbral_LOW(Umbral_LOW), .data_out(data_out),
    .valid_out(valid_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_error(fifo_error),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    Umbral_HIGH = 4'd0;
    Umbral_LOW = 4'd0;
    apply_reset();
    checks++;
    if ({count, fifo_empty, fifo_full, almost_empty, almost_full, fifo_error, valid_out, data_out}
        !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_state got cnt=%0d e=%b f=%b ae=%b af=%b err=%b v=%b d=%h", count,
               fifo_empty, fifo_full, almost_empty, almost_full, fifo_error, valid_out, data_out);
    end
  endtask

  task automatic test_fill_thresholds();
    apply_reset();
    Umbral_HIGH = 4'd6;
    Umbral_LOW = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1;
      data_in = 6'(i);
      sb.push_back(6'(i));
      step();
      checks++;
      if ({count, almost_empty, almost_full, fifo_full, fifo_error, valid_out}
          !== {4'(i), (i <= 2), (i >= 6), (i == 8), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL fill_%0d got cnt=%0d ae=%b af=%b f=%b err=%b v=%b required cnt=%0d ae=%b af=%b f=%b",
                 i, count, almost_empty, almost_full, fifo_full, fifo_error, valid_out,
                 i, (i <= 2), (i >= 6), (i == 8));
      end
    end
    push = 1'b0;
  endtask

  task automatic test_overflow_drain();
    push = 1'b1;
    data_in = 6'h3F;
    step();
    push = 1'b0;
    checks++;
    if ({fifo_error, count} !== {1'b1, 4'd8}) begin
      failures++;
      $display("FAIL overflow got err=%b cnt=%0d required err=1 cnt=8", fifo_error, count);
    end
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      exp_d = sb.pop_front();
      step();
      checks++;
      if ({valid_out, data_out} !== {1'b1, exp_d}) begin
        failures++;
        $display("FAIL drain_%0d got v=%b d=%h required v=1 d=%h", i, valid_out, data_out, exp_d);
      end
    end
    pop = 1'b0;
    step();
    checks++;
    if ({fifo_empty, fifo_error, valid_out, count} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL drain_end got e=%b err=%b v=%b cnt=%0d required e=1 err=1 v=0 cnt=0",
               fifo_empty, fifo_error, valid_out, count);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      data_in = 6'(8'h10 + i);
      sb.push_back(data_in);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      push = 1'b1;
      pop = 1'b1;
      exp_d = sb.pop_front();
      data_in = 6'(8'h20 + i);
      sb.push_back(data_in);
      step();
      checks++;
      if ({valid_out, data_out, count, fifo_error} !== {1'b1, exp_d, 4'd8, 1'b0}) begin
        failures++;
        $display("FAIL full_pp_%0d got v=%b d=%h cnt=%0d err=%b required v=1 d=%h cnt=8 err=0",
                 i, valid_out, data_out, count, fifo_error, exp_d);
      end
    end
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic test_underflow_push();
    apply_reset();
    push = 1'b1;
    pop = 1'b1;
    data_in = 6'h15;
    sb.push_back(6'h15);
    step();
    push = 1'b0;
    checks++;
    if ({fifo_error, count, valid_out} !== {1'b1, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL underflow got err=%b cnt=%0d v=%b required err=1 cnt=1 v=0",
               fifo_error, count, valid_out);
    end
    exp_d = sb.pop_front();
    step();
    pop = 1'b0;
    checks++;
    if ({valid_out, data_out, count} !== {1'b1, exp_d, 4'd0}) begin
      failures++;
      $display("FAIL underflow_read got v=%b d=%h cnt=%0d required v=1 d=%h cnt=0",
               valid_out, data_out, count, exp_d);
    end
  endtask

  task automatic test_disabled_thresholds();
    apply_reset();
    Umbral_HIGH = 4'd0;
    Umbral_LOW = 4'd0;
    for (int i = 0; i < 7; i++) begin
      push = 1'b1;
      data_in = 6'(i);
      step();
    end
    checks++;
    if ({count, almost_full, almost_empty} !== {4'd7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL disabled_7 got cnt=%0d af=%b ae=%b required cnt=7 af=0 ae=0",
               count, almost_full, almost_empty);
    end
    step();
    push = 1'b0;
    checks++;
    if ({count, almost_full, fifo_full} !== {4'd8, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL disabled_8 got cnt=%0d af=%b f=%b required cnt=8 af=1 f=1",
               count, almost_full, fifo_full);
    end
    Umbral_HIGH = 4'd12;
    #1;
    checks++;
    if (almost_full !== 1'b0) begin
      failures++;
      $display("FAIL high_above_depth got af=%b required af=0", almost_full);
    end
    Umbral_HIGH = 4'd0;
  endtask

  task automatic test_async_reset();
    time t_rst;
    apply_reset();
    Umbral_HIGH = 4'd6;
    Umbral_LOW = 4'd2;
    pop = 1'b1;
    step();
    pop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push = 1'b1;
      data_in = 6'(8'h31 + i);
      step();
    end
    push = 1'b0;
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if ({count, fifo_error, data_out} !== {4'd5, 1'b1, 6'h31}) begin
      failures++;
      $display("FAIL pre_reset got cnt=%0d err=%b d=%h required cnt=5 err=1 d=31",
               count, fifo_error, data_out);
    end
    push = 1'b1;
    data_in = 6'h2A;
    #2;
    t_rst = $time;
    reset_L = 1'b0;
    #1;
    checks++;
    if (({count, fifo_empty, fifo_full, almost_empty, almost_full, fifo_error, valid_out, data_out}
         !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) || ($time - t_rst >= 5)) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d e=%b f=%b ae=%b af=%b err=%b v=%b d=%h", count,
               fifo_empty, fifo_full, almost_empty, almost_full, fifo_error, valid_out, data_out);
    end
    reset_L = 1'b1;
    step();
    push = 1'b0;
    checks++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL first_push_after_reset got cnt=%0d required cnt=1", count);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++;
    if ({valid_out, data_out} !== {1'b1, 6'h2A}) begin
      failures++;
      $display("FAIL post_reset_read got v=%b d=%h required v=1 d=2a", valid_out, data_out);
    end
  endtask

  initial begin
    reset_L = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    Umbral_HIGH = '0;
    Umbral_LOW = '0;
    test_reset();
    test_fill_thresholds();
    test_overflow_drain();
    test_full_push_pop();
    test_underflow_push();
    test_disabled_thresholds();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
